// File: rtl/fir_capture_pkg.sv
// Shared types and sizing helpers for the FIR response capture block.
// Optional running sum enabled by FIR_RESP_CAPTURE_SUM_EN.
package fir_capture_pkg;

  localparam int DEF_DW    = 33;
  localparam int DEF_DEPTH = 64;
  localparam int DEF_SKIP  = 0;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    READOUT
  } cap_state_e;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fir_capture_mem.sv
// Capture buffer: one write port, one registered read port.
// Plain array with no reset so it maps onto block RAM.
module fir_capture_mem #(
  parameter int DATA_WIDTH = 33,
  parameter int DEPTH      = 64,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port and registered read port.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fir_resp_capture.sv
// Capture of a FIR output stream with valid/ready readout.
// Define FIR_RESP_CAPTURE_SUM_EN to add the signed sum output.
module fir_resp_capture
  import fir_capture_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DW,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int SKIP       = DEF_SKIP
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      arm,
  input  logic                      valid_in,
  input  logic [DATA_WIDTH-1:0]     din,
  output logic                      busy,
  output logic                      done,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      rd_last
`ifdef FIR_RESP_CAPTURE_SUM_EN
  ,
  output logic signed [DATA_WIDTH+$clog2(DEPTH)-1:0] sum
`endif
);

  localparam int CW = cnt_w(DEPTH);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
`ifdef FIR_RESP_CAPTURE_SUM_EN
  localparam int SUM_W = DATA_WIDTH + $clog2(DEPTH);
`endif

  cap_state_e state, nxt;

  logic [SW-1:0]         skip_cnt;
  logic [CW-1:0]         rd_idx;
  logic                  out_v, out_last;
  logic                  sk_v, sk_last;
  logic [DATA_WIDTH-1:0] sk_q;
  logic                  pend, pend_last;
  logic [DATA_WIDTH-1:0] mem_q;
  logic [1:0]            items;
  logic                  wr_en, pop, last_pop;
  logic                  enter_ro, issue;

  assign wr_en    = (state == CAPTURE) && valid_in;
  assign pop      = out_v && rd_ready;
  assign last_pop = pop && out_last;
  assign enter_ro = wr_en && (count == CW'(DEPTH - 1));
  assign items    = 2'(out_v) + 2'(sk_v) + 2'(pend);
  // Fetch only when the output and skid registers can absorb it.
  assign issue    = (state == READOUT)
                 && (rd_idx < CW'(DEPTH))
                 && ((items - 2'(pop)) < 2'd2);

  assign rd_valid = out_v;
  assign rd_last  = out_v && out_last;

  fir_capture_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (count[AW-1:0]),
    .wr_data (din),
    .rd_en   (issue),
    .rd_addr (rd_idx[AW-1:0]),
    .rd_data (mem_q)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next-state decode and busy flag.
  always_comb begin
    nxt  = state;
    busy = (state != IDLE);
    unique case (state)
      IDLE:
        if (arm) nxt = (SKIP > 0) ? ARMED : CAPTURE;
      ARMED:
        if (valid_in && (skip_cnt == SW'(SKIP - 1)))
          nxt = CAPTURE;
      CAPTURE:
        if (enter_ro) nxt = READOUT;
      READOUT:
        if (last_pop) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Run counters, done pulse and optional sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      skip_cnt <= '0;
      done     <= 1'b0;
`ifdef FIR_RESP_CAPTURE_SUM_EN
      sum      <= '0;
`endif
    end else begin
      done <= (state == READOUT) && last_pop;
      if ((state == IDLE) && arm) begin
        count    <= '0;
        skip_cnt <= '0;
`ifdef FIR_RESP_CAPTURE_SUM_EN
        sum      <= '0;
`endif
      end
      if ((state == ARMED) && valid_in)
        skip_cnt <= skip_cnt + 1'b1;
      if (wr_en) begin
        count <= count + 1'b1;
`ifdef FIR_RESP_CAPTURE_SUM_EN
        sum   <= sum + SUM_W'(signed'(din));
`endif
      end
    end
  end

  // Readout path: samples 0 and 1 are snooped from din into the
  // output and skid registers, so READOUT starts with two words
  // ready while the RAM read latency for word 2 is hidden.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_v     <= 1'b0;
      out_last  <= 1'b0;
      rd_data   <= '0;
      sk_v      <= 1'b0;
      sk_last   <= 1'b0;
      sk_q      <= '0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
      rd_idx    <= '0;
    end else begin
      pend      <= issue;
      pend_last <= issue && (rd_idx == CW'(DEPTH - 1));
      if (wr_en && (count == '0)) begin
        rd_data  <= din;
        out_last <= 1'b0;
      end
      if (wr_en && (count == CW'(1))) begin
        sk_q    <= din;
        sk_last <= (DEPTH == 2);
      end
      if (enter_ro) begin
        out_v  <= 1'b1;
        sk_v   <= 1'b1;
        rd_idx <= CW'(2);
      end else if (state == READOUT) begin
        if (issue) rd_idx <= rd_idx + 1'b1;
        if (!out_v || pop) begin
          if (sk_v) begin
            rd_data  <= sk_q;
            out_last <= sk_last;
            out_v    <= 1'b1;
            sk_v     <= pend;
            if (pend) begin
              sk_q    <= mem_q;
              sk_last <= pend_last;
            end
          end else if (pend) begin
            rd_data  <= mem_q;
            out_last <= pend_last;
            out_v    <= 1'b1;
          end else begin
            out_v <= 1'b0;
          end
        end else if (pend) begin
          sk_v    <= 1'b1;
          sk_q    <= mem_q;
          sk_last <= pend_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_resp_capture.sv
// Scoreboard bench for fir_resp_capture (DEPTH=8, SKIP=2 and SKIP=0).
// Sum checks are compiled in with FIR_RESP_CAPTURE_SUM_EN.
module tb_fir_resp_capture;

  localparam int DW    = 33;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef FIR_RESP_CAPTURE_SUM_EN
  localparam int SUM_W = DW + $clog2(DEPTH);
`endif

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          arm = 1'b0;
  logic          arm0 = 1'b0;
  logic          valid_in = 1'b0;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] din = '0;

  logic          busy, done, rd_valid, rd_last;
  logic [CW-1:0] count;
  logic [DW-1:0] rd_data;
  logic          busy0, done0, rd_valid0, rd_last0;
  logic [CW-1:0] count0;
  logic [DW-1:0] rd_data0;
`ifdef FIR_RESP_CAPTURE_SUM_EN
  logic signed [SUM_W-1:0] sum, sum0;
  logic signed [SUM_W-1:0] exp_sum;
`endif

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  exp_t exp0_q[$];
  int   ready_mode = 0;
  int   pc = 0;
  logic [7:0] pat = 8'b01101001;

  always #5 clk = ~clk;

  fir_resp_capture #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .SKIP       (2)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .arm      (arm),
    .valid_in (valid_in),
    .din      (din),
    .busy     (busy),
    .done     (done),
    .count    (count),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .rd_last  (rd_last)
`ifdef FIR_RESP_CAPTURE_SUM_EN
    ,
    .sum      (sum)
`endif
  );

  fir_resp_capture #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .SKIP       (0)
  ) u_dut0 (
    .clk      (clk),
    .rst      (rst),
    .arm      (arm0),
    .valid_in (valid_in),
    .din      (din),
    .busy     (busy0),
    .done     (done0),
    .count    (count0),
    .rd_valid (rd_valid0),
    .rd_ready (rd_ready),
    .rd_data  (rd_data0),
    .rd_last  (rd_last0)
`ifdef FIR_RESP_CAPTURE_SUM_EN
    ,
    .sum      (sum0)
`endif
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    pc++;
    rd_ready = (ready_mode == 0) ? 1'b1 : pat[pc % 8];
  end

  initial begin
    logic          pend_done, stall, hold_l;
    logic [DW-1:0] hold_d;
    exp_t          e;
    pend_done = 0; stall = 0; hold_l = 0; hold_d = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend_done = 0;
        stall = 0;
      end else begin
        chk("done", done, pend_done);
        pend_done = 0;
        if (stall) begin
          chk("stall_valid", rd_valid, 1);
          chk("stall_data", rd_data, hold_d);
          chk("stall_last", rd_last, hold_l);
        end
        if (rd_valid && rd_ready) begin
          if (exp_q.size() == 0) chk("extra_rd", exp_q.size(), 1);
          else begin
            e = exp_q.pop_front();
            chk("rd_data", rd_data, e.data);
            chk("rd_last", rd_last, e.last);
            pend_done = e.last;
          end
        end
        stall  = rd_valid && !rd_ready;
        hold_d = rd_data;
        hold_l = rd_last;
      end
    end
  end

  initial begin
    logic          pend_done, stall, hold_l;
    logic [DW-1:0] hold_d;
    exp_t          e;
    pend_done = 0; stall = 0; hold_l = 0; hold_d = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend_done = 0;
        stall = 0;
      end else begin
        chk("done0", done0, pend_done);
        pend_done = 0;
        if (stall) begin
          chk("stall_valid0", rd_valid0, 1);
          chk("stall_data0", rd_data0, hold_d);
          chk("stall_last0", rd_last0, hold_l);
        end
        if (rd_valid0 && rd_ready) begin
          if (exp0_q.size() == 0) chk("extra_rd0", exp0_q.size(), 1);
          else begin
            e = exp0_q.pop_front();
            chk("rd_data0", rd_data0, e.data);
            chk("rd_last0", rd_last0, e.last);
            pend_done = e.last;
          end
        end
        stall  = rd_valid0 && !rd_ready;
        hold_d = rd_data0;
        hold_l = rd_last0;
      end
    end
  end

  task automatic capture(input bit sel, input int n, input int base,
                         input int step, input bit gaps);
    int   skip, k, cyc;
    exp_t e;
    skip = sel ? 0 : 2;
    k = 0;
    cyc = 0;
    if (sel) arm0 = 1'b1;
    else     arm  = 1'b1;
    @(posedge clk); #1;
    arm  = 1'b0;
    arm0 = 1'b0;
    while (k < n) begin
      if (gaps && (cyc % 3 == 2)) begin
        valid_in = 1'b0;
        din = DW'($urandom);
      end else begin
        valid_in = 1'b1;
        din = DW'(base + k * step);
        if (k >= skip && k < skip + DEPTH) begin
          e.data = din;
          e.last = (k == skip + DEPTH - 1);
          if (sel) exp0_q.push_back(e);
          else     exp_q.push_back(e);
        end
        k++;
      end
      cyc++;
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input string tag);
    bit seen;
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      seen = sel ? done0 : done;
    end
    chk({tag, "_done_seen"}, seen, 1);
    @(posedge clk); #1;
    if (sel) begin
      chk({tag, "_busy"}, busy0, 0);
      chk({tag, "_rd_valid"}, rd_valid0, 0);
      chk({tag, "_rd_last"}, rd_last0, 0);
      chk({tag, "_count"}, count0, DEPTH);
      chk({tag, "_left"}, exp0_q.size(), 0);
    end else begin
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_rd_valid"}, rd_valid, 0);
      chk({tag, "_rd_last"}, rd_last, 0);
      chk({tag, "_count"}, count, DEPTH);
      chk({tag, "_left"}, exp_q.size(), 0);
    end
  endtask

  task automatic wait_rd_valid0(input string tag);
    bit seen;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = rd_valid0;
    end
    chk({tag, "_ro_entry"}, seen, 1);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_last", rd_last, 0);
    chk("rst_count", count, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_busy0", busy0, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    ready_mode = 0;
    capture(0, 12, 1, 1, 0);
    wait_done(0, "cont");

    capture(0, 12, 1, 1, 1);
    wait_done(0, "gap");

    ready_mode = 1;
    capture(0, 12, 20, 3, 0);
    wait_done(0, "bp");
    ready_mode = 0;

    capture(0, 6, 1, 1, 0);
    chk("abort_count_pre", count, 4);
    chk("abort_busy_pre", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_count", count, 0);
    chk("abort_rd_valid", rd_valid, 0);
    chk("abort_done", done, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_idle", busy, 0);

    ready_mode = 1;
    capture(1, 8, 100, 1, 0);
    wait_rd_valid0("rearm");
    @(posedge clk); #1;
    arm0 = 1'b1;
    @(posedge clk); #1;
    arm0 = 1'b0;
    chk("arm_ro_busy", busy0, 1);
    chk("arm_ro_count", count0, DEPTH);
    wait_done(1, "rearm");
    ready_mode = 0;

    capture(1, 8, -5, 0, 1);
    wait_rd_valid0("sum");
`ifdef FIR_RESP_CAPTURE_SUM_EN
    exp_sum = -40;
    chk("sum_final", sum0, exp_sum);
`endif
    wait_done(1, "sum");
`ifdef FIR_RESP_CAPTURE_SUM_EN
    chk("sum_hold", sum0, exp_sum);
`endif
    arm0 = 1'b1;
    @(posedge clk); #1;
    arm0 = 1'b0;
    chk("rearm_busy", busy0, 1);
    chk("rearm_count", count0, 0);
`ifdef FIR_RESP_CAPTURE_SUM_EN
    exp_sum = 0;
    chk("sum_clear", sum0, exp_sum);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
